ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The module SHALL have parameter IW, default 32, meaning instruction and address width.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-003 The module SHALL have the following ports, clock and reset first:
- clk  in  1  single clock, all state on its rising edge
- reset  in  1  synchronous, active-low reset
- o_mem_addr  out  IW  instruction memory word address
- o_mem_rd  out  1  memory read request
- o_mem_byte_en  out  4  byte enable, constant 4'hF
- i_mem_rddata  in  IW  read data, valid exactly 1 cycle after o_mem_rd
- o_instr_valid  out  1  queue head valid
- o_instr  out  IW  instruction at the queue head
- o_instr_pc  out  IW  PC of the queue head
- i_instr_ready  in  1  consumer accepts the head
- i_redirect  in  1  flush the queue and restart fetch
- i_redirect_pc  in  IW  restart PC
- o_count  out  $clog2(DEPTH+1)  occupied entries

Function
REQ-004 fpc (fetch PC register) SHALL hold the address of the next request; o_mem_addr SHALL equal fpc.
REQ-005 o_mem_rd SHALL be 1 if and only if reset=1, i_redirect=0 and (count + inflight) < DEPTH. Pops in the same cycle SHALL NOT be credited.
REQ-006 Each issued request SHALL advance fpc by 4 at the clock edge, with 32-bit wrap (0xFFFFFFFC -> 0x00000000), and SHALL set inflight=1 and inflight_pc=fpc.
REQ-007 When inflight=1 and no redirect occurs in that cycle, the module SHALL push {inflight_pc, i_mem_rddata} into the queue at the clock edge ending that cycle, then clear inflight unless a new request issued.
REQ-008 o_instr_valid SHALL be (count != 0); o_instr and o_instr_pc SHALL come combinationally from the head entry.
REQ-009 A pop SHALL occur when o_instr_valid=1 and i_instr_ready=1; a simultaneous push and pop SHALL leave count unchanged.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH. A push into a full queue SHALL be impossible by construction (REQ-005); an assertion SHALL flag it.
REQ-011 Redirect behaviour when i_redirect=1:
- clear the queue (count=0, pointers equal)
- discard any in-flight response (no push)
- load fpc = {i_redirect_pc[IW-1:2], 2'b00}
- issue no request in that cycle
REQ-012 A redirect SHALL take priority over a simultaneous pop or push; the first request SHALL issue at the new PC in the next cycle.
REQ-013 Latency: an instruction requested in cycle N SHALL appear at the head no earlier than cycle N+2. Steady-state throughput SHALL be 1 instruction per cycle while the consumer is ready.
REQ-014 o_count SHALL always equal (pushes - pops) since the last reset or redirect, within 0..DEPTH.

Reset
REQ-015 While reset=0 the module SHALL drive o_mem_rd=0 and o_instr_valid=0.
REQ-016 At a clock edge with reset=0 the module SHALL set fpc=0, count=0, pointers=0, inflight=0 and inflight_pc=0. A response outstanding during reset SHALL be dropped.
REQ-017 o_mem_byte_en SHALL be 4'hF in all states, including reset.

Structure
REQ-018 A shared package ifq_pkg SHALL hold the default IW and DEPTH, the constant IFQ_BYTE_EN_WORD = 4'hF, and the entry struct typedef ifq_entry_t {pc, instr}.
REQ-019 Entry storage and pointers SHALL live in one sub-module ifq_fifo (push, pop, flush, count, head). Fetch control (fpc, inflight, credit logic) SHALL stay in ifetch_queue.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, with a latency-1 memory model where mem[a] = a ^ 0xA5A50000:
- Reset release with ready=1 -> o_mem_rd=1 with o_mem_addr=0 in the first cycle; head pc=0, instr=0xA5A50000 in the third cycle; then one instruction per cycle at pc 4, 8, 12.
- ready=0 held for 10 cycles -> exactly 4 requests issued (0..12); o_count saturates at 4; o_mem_rd=0 afterwards; no data lost when ready returns.
- Queue full (count=4), then pop and redirect to 0x00000102 in the same cycle -> next cycle count=0 with no valid; request at 0x00000100; the stale in-flight response is never seen.
- Redirect while one request is in flight to 0x200 -> the response for the old PC is dropped; the first head pc is 0x200.
- Redirect to 0xFFFFFFF8 with ready=1 -> head pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- reset=0 asserted with count=3 and inflight=1 -> after the edge, count=0, o_instr_valid=0 and fpc=0; the late response is not pushed.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: default sizes,
// the constant memory byte enable and the queue entry layout.
package ifq_pkg;

  localparam int IFQ_IW    = 32;
  localparam int IFQ_DEPTH = 4;

  localparam logic [3:0] IFQ_BYTE_EN_WORD = 4'hF;

  typedef struct packed {
    logic [IFQ_IW-1:0] pc;
    logic [IFQ_IW-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch queue's memory-side and consumer-side signals.
// The master modport is the queue's view; slave is the environment's view.
interface ifetch_queue_if #(
  parameter int IW = 32,
  parameter int CW = 3
);

  logic [IW-1:0] mem_addr;
  logic          mem_rd;
  logic [3:0]    mem_byte_en;
  logic [IW-1:0] mem_rddata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [IW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [IW-1:0] redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output mem_addr, mem_rd, mem_byte_en, instr_valid, instr, instr_pc, count,
    input  mem_rddata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_rd, mem_byte_en, instr_valid, instr, instr_pc, count,
    output mem_rddata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// Entry storage for the fetch queue: circular buffer of {pc, instr}
// with push, pop, flush and an occupancy count. Head is combinational.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int IW    = IFQ_IW,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [IW-1:0]                push_pc,
  input  logic [IW-1:0]                push_instr,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [IW-1:0]                head_pc,
  output logic [IW-1:0]                head_instr
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Pointer and count bookkeeping; flush empties the queue and realigns pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry write; storage itself is data and carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset) (push && !flush) |-> (count != CW'(DEPTH))
  ) else $error("ifq_fifo: push into a full queue");

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word reads to a latency-1
// memory, buffers returned words with their PCs, and serves them to a
// consumer. A redirect flushes everything and restarts at a new PC.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int IW    = IFQ_IW,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [IW-1:0]               o_mem_addr,
  output logic                        o_mem_rd,
  output logic [3:0]                  o_mem_byte_en,
  input  logic [IW-1:0]               i_mem_rddata,
  output logic                        o_instr_valid,
  output logic [IW-1:0]               o_instr,
  output logic [IW-1:0]               o_instr_pc,
  input  logic                        i_instr_ready,
  input  logic                        i_redirect,
  input  logic [IW-1:0]               i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]  o_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [IW-1:0] fpc;
  logic          vld_p1;
  logic [IW-1:0] pc_p1;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  logic [IW-1:0] redirect_base;

  // Credit counts queued entries plus the one response that may still be
  // on its way; pops in the current cycle are deliberately not credited.
  assign occupancy     = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign issue         = reset & ~i_redirect & (occupancy < (CW+1)'(DEPTH));
  assign push          = reset & ~i_redirect & vld_p1;
  assign o_instr_valid = reset & (count != '0);
  assign pop           = o_instr_valid & i_instr_ready & ~i_redirect;
  assign redirect_base = i_redirect_pc & ~IW'(3);

  assign o_mem_addr    = fpc;
  assign o_mem_rd      = issue;
  assign o_mem_byte_en = IFQ_BYTE_EN_WORD;
  assign o_count       = count;

  // Fetch PC and in-flight tracking (stage p1 = response arriving this cycle).
  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc    <= '0;
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
    end else if (i_redirect) begin
      fpc    <= redirect_base;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        fpc   <= fpc + IW'(4);
        pc_p1 <= fpc;
      end
    end
  end

  ifq_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (i_redirect),
    .push       (push),
    .push_pc    (pc_p1),
    .push_instr (i_mem_rddata),
    .pop        (pop),
    .count      (count),
    .head_pc    (o_instr_pc),
    .head_instr (o_instr)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a latency-1 memory model
// where mem[a] = a ^ 0xA5A50000.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if #(.IW(IW), .CW(CW)) bus ();

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .o_mem_addr    (bus.mem_addr),
    .o_mem_rd      (bus.mem_rd),
    .o_mem_byte_en (bus.mem_byte_en),
    .i_mem_rddata  (bus.mem_rddata),
    .o_instr_valid (bus.instr_valid),
    .o_instr       (bus.instr),
    .o_instr_pc    (bus.instr_pc),
    .i_instr_ready (bus.instr_ready),
    .i_redirect    (bus.redirect),
    .i_redirect_pc (bus.redirect_pc),
    .o_count       (bus.count)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  // Latency-1 memory: data for a request appears the cycle after it.
  always_ff @(posedge clk)
    bus.mem_rddata <= bus.mem_rd ? memval(bus.mem_addr) : 32'hDEADBEEF;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, releases it; returns 2 units into cycle 0.
  task automatic begin_run(input logic rdy);
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = rdy;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %0b want 0", bus.mem_rd); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); end
    n_tests++; if (bus.mem_byte_en !== 4'hF) begin n_fail++; $display("FAIL reset_byte_en: got %h want f", bus.mem_byte_en); end
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.mem_byte_en !== 4'hF) begin n_fail++; $display("FAIL run_byte_en: got %h want f", bus.mem_byte_en); end
  endtask

  task automatic test_basic;
    begin_run(1'b1);
    n_tests++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL basic_rd0: got %0b want 1", bus.mem_rd); end
    n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr0: got %h want 0", bus.mem_addr); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid0: got %0b want 0", bus.instr_valid); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid1: got %0b want 0", bus.instr_valid); end
    n_tests++; if (bus.mem_addr !== 32'h4 || bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL basic_req1: got addr %h rd %0b want 4/1", bus.mem_addr, bus.mem_rd); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      else begin next_cycle(); #1; end
      n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid k=%0d: got %0b want 1", k, bus.instr_valid); end
      n_tests++; if (bus.instr_pc !== 32'(4*k)) begin n_fail++; $display("FAIL basic_pc k=%0d: got %h want %h", k, bus.instr_pc, 32'(4*k)); end
      n_tests++; if (bus.instr !== memval(32'(4*k))) begin n_fail++; $display("FAIL basic_instr k=%0d: got %h want %h", k, bus.instr, memval(32'(4*k))); end
    end
    n_tests++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", bus.count); end
  endtask

  task automatic test_stall;
    int issued;
    issued = 0;
    begin_run(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin next_cycle(); #1; end
      if (bus.mem_rd === 1'b1) begin
        n_tests++; if (bus.mem_addr !== 32'(4*issued)) begin n_fail++; $display("FAIL stall_addr: got %h want %h", bus.mem_addr, 32'(4*issued)); end
        issued++;
      end
    end
    n_tests++; if (issued != 4) begin n_fail++; $display("FAIL stall_issued: got %0d want 4", issued); end
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", bus.count); end
    n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd: got %0b want 0", bus.mem_rd); end
    next_cycle();
    bus.instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4*k)) begin n_fail++; $display("FAIL stall_drain_pc k=%0d: got v%0b pc %h want v1 pc %h", k, bus.instr_valid, bus.instr_pc, 32'(4*k)); end
      n_tests++; if (bus.instr !== memval(32'(4*k))) begin n_fail++; $display("FAIL stall_drain_instr k=%0d: got %h want %h", k, bus.instr, memval(32'(4*k))); end
    end
  endtask

  task automatic test_full_redirect;
    bit reached;
    reached = 1'b0;
    begin_run(1'b0);
    for (int i = 0; i < 20 && !reached; i++) begin
      if (bus.count === 3'd4) reached = 1'b1;
      else begin next_cycle(); #1; end
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL full_timeout: count %0d want 4 within 20 cycles", bus.count); end
    next_cycle();
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h00000102;
    #1;
    n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL full_redir_rd: got %0b want 0", bus.mem_rd); end
    next_cycle();
    bus.redirect = 1'b0;
    #1;
    n_tests++; if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush: got count %0d v%0b want 0/0", bus.count, bus.instr_valid); end
    n_tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL full_restart: got rd %0b addr %h want 1/100", bus.mem_rd, bus.mem_addr); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_gap: got v%0b want 0", bus.instr_valid); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== memval(32'h100)) begin n_fail++; $display("FAIL full_head0: got v%0b pc %h instr %h want 1/100/%h", bus.instr_valid, bus.instr_pc, bus.instr, memval(32'h100)); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_pc !== 32'h104) begin n_fail++; $display("FAIL full_head1: got %h want 104", bus.instr_pc); end
  endtask

  task automatic test_redirect_inflight;
    begin_run(1'b1);
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h00000200;
    #1;
    n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL infl_rd: got %0b want 0", bus.mem_rd); end
    next_cycle();
    bus.redirect = 1'b0;
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0 || bus.count !== 3'd0) begin n_fail++; $display("FAIL infl_drop: got v%0b count %0d want 0/0", bus.instr_valid, bus.count); end
    n_tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL infl_restart: got rd %0b addr %h want 1/200", bus.mem_rd, bus.mem_addr); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL infl_gap: got v%0b want 0", bus.instr_valid); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== memval(32'h200)) begin n_fail++; $display("FAIL infl_head0: got v%0b pc %h instr %h want 1/200/%h", bus.instr_valid, bus.instr_pc, bus.instr, memval(32'h200)); end
    next_cycle(); #1;
    n_tests++; if (bus.instr_pc !== 32'h204) begin n_fail++; $display("FAIL infl_head1: got %h want 204", bus.instr_pc); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFFFFF8;
    exp_pc[1] = 32'hFFFFFFFC;
    exp_pc[2] = 32'h00000000;
    begin_run(1'b1);
    next_cycle();
    next_cycle();
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFFFFF8;
    #1;
    next_cycle();
    bus.redirect = 1'b0;
    #1;
    n_tests++; if (bus.mem_addr !== 32'hFFFFFFF8 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_restart: got addr %h v%0b want fffffff8/0", bus.mem_addr, bus.instr_valid); end
    next_cycle(); #1;
    n_tests++; if (bus.mem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_req1: got %h want fffffffc", bus.mem_addr); end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[k] || bus.instr !== memval(exp_pc[k])) begin n_fail++; $display("FAIL wrap_head k=%0d: got v%0b pc %h instr %h want 1/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instr, exp_pc[k], memval(exp_pc[k])); end
    end
  endtask

  task automatic test_reset_midflight;
    begin_run(1'b0);
    for (int i = 0; i < 4; i++) begin next_cycle(); #1; end
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 3", bus.count); end
    reset = 1'b0;
    #1;
    n_tests++; if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got rd %0b v%0b want 0/0", bus.mem_rd, bus.instr_valid); end
    next_cycle();
    reset = 1'b1;
    #1;
    n_tests++; if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_cleared: got count %0d v%0b want 0/0", bus.count, bus.instr_valid); end
    n_tests++; if (bus.mem_addr !== 32'h0 || bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_fpc: got addr %h rd %0b want 0/1", bus.mem_addr, bus.mem_rd); end
    next_cycle(); #1;
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL mid_no_late_push: got count %0d want 0", bus.count); end
    next_cycle(); #1;
    n_tests++; if (bus.count !== 3'd1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'hA5A50000) begin n_fail++; $display("FAIL mid_head: got count %0d pc %h instr %h want 1/0/a5a50000", bus.count, bus.instr_pc, bus.instr); end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_full_redirect();
    test_redirect_inflight();
    test_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
